// File: rtl/distance_monitor_pkg.sv
// Shared types and default timing constants for the distance monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package distance_monitor_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    REQUEST     = 3'd1,
    WAIT_RESULT = 3'd2,
    CAPTURE     = 3'd3,
    WAIT_PERIOD = 3'd4
  } state_t;

  // 100 MHz defaults: 60 ms request spacing, 40 ms echo window.
  localparam int unsigned DEF_SAMPLE_PERIOD = 6_000_000;
  localparam int unsigned DEF_READ_HOLD     = 256;
  localparam int unsigned DEF_RESP_TIMEOUT  = 4_000_000;
  localparam int unsigned DEF_AVG_LOG2      = 2;
  localparam logic [31:0] DEF_NEAR_THRESH   = 32'd20000;
  localparam logic [31:0] DEF_FAR_THRESH    = 32'd25000;

endpackage

// File: rtl/distance_monitor_if.sv
// Bundles the enable, sensor handshake and result signals of the distance monitor.
// Latency: n/a (wiring only).
// Backpressure: none; READ/DISTANCE_VALID form a level handshake with no stall path.
interface distance_monitor_if;
  logic        en;
  logic        READ;
  logic [31:0] DISTANCE;
  logic        DISTANCE_VALID;
  logic [31:0] avg_distance;
  logic        avg_valid;
  logic        object_near;
  logic        no_echo;

  // Monitor side: drives the request and the results.
  modport master (
    input  en, DISTANCE, DISTANCE_VALID,
    output READ, avg_distance, avg_valid, object_near, no_echo
  );

  // Environment side: sensor controller plus result consumer.
  modport slave (
    output en, DISTANCE, DISTANCE_VALID,
    input  READ, avg_distance, avg_valid, object_near, no_echo
  );
endinterface

// File: rtl/distance_monitor_sample_averager.sv
// Ring-buffer moving average over 2**AVG_LOG2 samples with a running sum.
// Latency: avg_vld/avg_dat appear 2 cycles after push_vld; silent until the buffer is full.
// Backpressure: none; accepts a push every cycle.
module sample_averager
  import distance_monitor_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_vld,
  input  logic [31:0] push_dat,
  output logic [31:0] avg_dat,
  output logic        avg_vld
);

  localparam int unsigned N  = 1 << AVG_LOG2;
  localparam int unsigned SW = 32 + AVG_LOG2;

  typedef logic [AVG_LOG2-1:0] ptr_t;
  typedef logic [AVG_LOG2:0]   fill_t;
  typedef logic [SW-1:0]       sum_t;

  localparam fill_t FULL = fill_t'(N);

  logic [31:0] mem_q [N];
  logic [31:0] mem_d [N];
  ptr_t        ptr_q, ptr_d;
  fill_t       fill_q, fill_d;
  sum_t        sum_q, sum_d;
  logic        upd_q, upd_d;
  logic [31:0] avg_q, avg_d;
  logic        avg_vld_q, avg_vld_d;

  // Write the new sample over the oldest slot and slide the running sum; publish the mean a cycle later.
  always_comb begin
    mem_d     = mem_q;
    ptr_d     = ptr_q;
    fill_d    = fill_q;
    sum_d     = sum_q;
    upd_d     = push_vld;
    avg_d     = avg_q;
    avg_vld_d = 1'b0;
    if (push_vld) begin
      mem_d[ptr_q] = push_dat;
      ptr_d        = ptr_q + ptr_t'(1);
      if (fill_q != FULL) begin
        fill_d = fill_q + fill_t'(1);
      end
      // Unwritten slots hold zero, so the subtraction is harmless while filling.
      sum_d = sum_q + sum_t'(push_dat) - sum_t'(mem_q[ptr_q]);
    end
    if (upd_q && (fill_q == FULL)) begin
      avg_d     = sum_q[SW-1:AVG_LOG2];
      avg_vld_d = 1'b1;
    end
  end

  // State registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q     <= '{default: '0};
      ptr_q     <= '0;
      fill_q    <= '0;
      sum_q     <= '0;
      upd_q     <= 1'b0;
      avg_q     <= '0;
      avg_vld_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      ptr_q     <= ptr_d;
      fill_q    <= fill_d;
      sum_q     <= sum_d;
      upd_q     <= upd_d;
      avg_q     <= avg_d;
      avg_vld_q <= avg_vld_d;
    end
  end

  assign avg_dat = avg_q;
  assign avg_vld = avg_vld_q;

endmodule

// File: rtl/distance_monitor.sv
// Paces the ultrasonic sensor with periodic READ requests, averages results, flags proximity and lost echoes.
// Latency: avg_valid 2 cycles after the capture cycle; object_near follows avg_valid by 1 cycle.
// Backpressure: none; results arriving outside WAIT_RESULT are dropped, en low parks the FSM in IDLE.
module distance_monitor
  import distance_monitor_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
  parameter int unsigned READ_HOLD     = DEF_READ_HOLD,
  parameter int unsigned RESP_TIMEOUT  = DEF_RESP_TIMEOUT,
  parameter int unsigned AVG_LOG2      = DEF_AVG_LOG2,
  parameter logic [31:0] NEAR_THRESH   = DEF_NEAR_THRESH,
  parameter logic [31:0] FAR_THRESH    = DEF_FAR_THRESH
) (
  input logic                clk,
  input logic                rst,
  distance_monitor_if.master mon
);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;     // READ hold length, then echo wait length
  logic [31:0] per_q, per_d;     // cycles since the current request started
  logic        dv_q, dv_d;
  logic        no_echo_q, no_echo_d;
  logic        near_q, near_d;
  logic        rise;
  logic        push_vld;
  logic [31:0] avg_dat;
  logic        avg_vld;

  assign rise = mon.DISTANCE_VALID & ~dv_q;

  // Request sequencing: hold READ, wait for the result edge or time out, then pad to the fixed period.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    per_d     = per_q;
    no_echo_d = no_echo_q;
    push_vld  = 1'b0;
    dv_d      = mon.DISTANCE_VALID;
    if (!mon.en) begin
      state_d = IDLE;
      cnt_d   = '0;
      per_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = REQUEST;
          cnt_d   = '0;
          per_d   = '0;
        end
        REQUEST: begin
          per_d = per_q + 32'd1;
          if (cnt_q == READ_HOLD - 1) begin
            state_d = WAIT_RESULT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        WAIT_RESULT: begin
          per_d = per_q + 32'd1;
          if (rise) begin
            state_d = CAPTURE;
            cnt_d   = '0;
          end else if (cnt_q == RESP_TIMEOUT - 1) begin
            state_d   = WAIT_PERIOD;
            cnt_d     = '0;
            no_echo_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        CAPTURE: begin
          per_d     = per_q + 32'd1;
          push_vld  = 1'b1;
          no_echo_d = 1'b0;
          state_d   = WAIT_PERIOD;
        end
        WAIT_PERIOD: begin
          if (per_q == SAMPLE_PERIOD - 1) begin
            state_d = REQUEST;
            per_d   = '0;
            cnt_d   = '0;
          end else begin
            per_d = per_q + 32'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Proximity flag with a dead band between the two thresholds.
  always_comb begin
    near_d = near_q;
    if (avg_vld) begin
      if (avg_dat < NEAR_THRESH) begin
        near_d = 1'b1;
      end else if (avg_dat > FAR_THRESH) begin
        near_d = 1'b0;
      end
    end
  end

  // Control and flag registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      per_q     <= '0;
      dv_q      <= 1'b0;
      no_echo_q <= 1'b0;
      near_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      dv_q      <= dv_d;
      no_echo_q <= no_echo_d;
      near_q    <= near_d;
    end
  end

  sample_averager #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push_vld),
    .push_dat (mon.DISTANCE),
    .avg_dat  (avg_dat),
    .avg_vld  (avg_vld)
  );

  assign mon.READ         = (state_q == REQUEST);
  assign mon.avg_distance = avg_dat;
  assign mon.avg_valid    = avg_vld;
  assign mon.object_near  = near_q;
  assign mon.no_echo      = no_echo_q;

endmodule
